// File: rtl/gfx_pkg.sv
// Shared graphics constants and types for the framebuffer/scanout path.
// Source is 400x240, 2x upscaled to an 800x480 panel.
package gfx_pkg;

  localparam int SRC_W    = 400;
  localparam int SRC_H    = 240;
  localparam int DISP_W   = 800;
  localparam int DISP_H   = 480;
  localparam int ADDR_W   = 17;
  localparam int WR_SHARE = 4;
  localparam int LB_XW    = 9;

  typedef struct packed {
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
    logic       a;
  } pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN
  } fetch_st_t;

endpackage

// File: rtl/fb_fetch_engine.sv
// Line prefetch engine: walks one source line of the framebuffer
// into a line-buffer bank, yielding a writer slot every WR_SHARE reads.
module fb_fetch_engine
  import gfx_pkg::*;
#(
  parameter int SRC_W    = gfx_pkg::SRC_W,
  parameter int ADDR_W   = gfx_pkg::ADDR_W,
  parameter int WR_SHARE = gfx_pkg::WR_SHARE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_base,
  input  logic              start_bank,
  input  logic              wr_valid,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_idx,
  output logic              wr_ready,
  output logic              lb_we,
  output logic [LB_XW:0]    lb_waddr
);

  localparam int SHW = $clog2(WR_SHARE + 1);

  fetch_st_t         state, state_d;
  logic [LB_XW-1:0]  x, x_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [SHW-1:0]    share, share_d;
  logic              bank, bank_d;
  logic              lb_we_q;
  logic [LB_XW:0]    lb_waddr_q;
  logic              slot_due;

  assign busy     = state != ST_IDLE;
  assign slot_due = share == SHW'(WR_SHARE);
  assign rd_idx   = addr;

  always_comb begin
    state_d  = state;
    x_d      = x;
    addr_d   = addr;
    share_d  = share;
    bank_d   = bank;
    rd_en    = 1'b0;
    wr_ready = 1'b0;
    unique case (state)
      ST_IDLE: wr_ready = wr_valid;
      ST_FETCH: begin
        if (slot_due && wr_valid) begin
          wr_ready = 1'b1;
          share_d  = '0;
        end else if (!start) begin
          rd_en   = 1'b1;
          addr_d  = addr + ADDR_W'(1);
          x_d     = x + LB_XW'(1);
          share_d = slot_due ? SHW'(1) : share + SHW'(1);
          if (x == LB_XW'(SRC_W - 1))
            state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // a restart always wins, even over an unfinished line
    if (start) begin
      state_d = ST_FETCH;
      x_d     = '0;
      addr_d  = start_base;
      share_d = '0;
      bank_d  = start_bank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      x          <= '0;
      addr       <= '0;
      share      <= '0;
      bank       <= 1'b0;
      lb_we_q    <= 1'b0;
      lb_waddr_q <= '0;
    end else begin
      state      <= state_d;
      x          <= x_d;
      addr       <= addr_d;
      share      <= share_d;
      bank       <= bank_d;
      lb_we_q    <= rd_en;
      lb_waddr_q <= {bank, x};
    end
  end

  // data still in flight from an aborted line is discarded
  assign lb_we    = lb_we_q & ~(start & busy);
  assign lb_waddr = lb_waddr_q;

endmodule

// File: rtl/fb_scanout_arbiter.sv
// Framebuffer port owner: shares the RAM between line prefetch and
// the pixel writer, and double-buffers frames with a front select.
module fb_scanout_arbiter
  import gfx_pkg::*;
#(
  parameter int SRC_W    = gfx_pkg::SRC_W,
  parameter int SRC_H    = gfx_pkg::SRC_H,
  parameter int ADDR_W   = gfx_pkg::ADDR_W,
  parameter int WR_SHARE = gfx_pkg::WR_SHARE
) (
  input  logic              clk_25mhz,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic [10:0]       next_y,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic              swap_req,
  output logic              swap_done,
  output logic              front,
  output logic [ADDR_W:0]   mem_addr,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              lb_we,
  output logic [9:0]        lb_waddr,
  output logic [15:0]       lb_wdata,
  output logic              disp_bank,
  output logic              underrun
);

  logic              pend;
  logic [ADDR_W-1:0] nxt_base;
  logic [10:0]       y_next_src;
  logic              ls_even, ls_fetch;
  logic              start, start_bank, busy;
  logic [ADDR_W-1:0] start_base;
  logic              rd_en, eng_ready, xfer;
  logic [ADDR_W-1:0] rd_idx;

  assign y_next_src = {1'b0, next_y[10:1]} + 11'd1;
  assign ls_even    = line_start & ~frame_start & ~next_y[0]
                    & (next_y < 11'(2 * SRC_H));
  assign ls_fetch   = ls_even & (y_next_src < 11'(SRC_H));

  assign start      = frame_start | ls_fetch;
  assign start_base = frame_start ? '0 : nxt_base;
  assign start_bank = frame_start ? 1'b0 : disp_bank;

  fb_fetch_engine #(
    .SRC_W    (SRC_W),
    .ADDR_W   (ADDR_W),
    .WR_SHARE (WR_SHARE)
  ) u_fetch (
    .clk        (clk_25mhz),
    .rst_n      (reset_n),
    .start      (start),
    .start_base (start_base),
    .start_bank (start_bank),
    .wr_valid   (wr_valid),
    .busy       (busy),
    .rd_en      (rd_en),
    .rd_idx     (rd_idx),
    .wr_ready   (eng_ready),
    .lb_we      (lb_we),
    .lb_waddr   (lb_waddr)
  );

  assign wr_ready = reset_n & eng_ready;
  assign xfer     = wr_valid & wr_ready;
  assign lb_wdata = mem_rdata;

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (1'b1)
      rd_en: mem_addr = {front, rd_idx};
      xfer: begin
        mem_we    = 1'b1;
        mem_addr  = {~front, wr_addr};
        mem_wdata = wr_data;
      end
      default: ;
    endcase
  end

  // row bases accumulate by SRC_W per fetched line
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      front     <= 1'b0;
      pend      <= 1'b0;
      swap_done <= 1'b0;
      disp_bank <= 1'b1;
      underrun  <= 1'b0;
      nxt_base  <= ADDR_W'(SRC_W);
    end else begin
      swap_done <= 1'b0;
      if (frame_start) begin
        if (pend | swap_req) begin
          front     <= ~front;
          swap_done <= 1'b1;
        end
        pend      <= 1'b0;
        disp_bank <= 1'b1;
        nxt_base  <= ADDR_W'(SRC_W);
      end else begin
        pend <= pend | swap_req;
        if (ls_even)
          disp_bank <= ~disp_bank;
        if (ls_fetch)
          nxt_base <= nxt_base + ADDR_W'(SRC_W);
      end
      if (start && busy)
        underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// Directed bench for fb_scanout_arbiter: idle arbitration table plus
// fetch, interleave, swap, underrun and reset sequences.
module tb_fb_scanout_arbiter;

  logic        clk_25mhz = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        line_start = 1'b0;
  logic [10:0] next_y = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [16:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        swap_req = 1'b0;
  logic        swap_done;
  logic        front;
  logic [17:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        lb_we;
  logic [9:0]  lb_waddr;
  logic [15:0] lb_wdata;
  logic        disp_bank;
  logic        underrun;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic        wv;
    logic [16:0] wa;
    logic [15:0] wd;
    logic        ex_rdy;
    logic        ex_we;
    logic [17:0] ex_addr;
    logic [15:0] ex_wd;
  } vec_t;

  vec_t tv[4];

  fb_scanout_arbiter dut (
    .clk_25mhz   (clk_25mhz),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .line_start  (line_start),
    .next_y      (next_y),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .swap_done   (swap_done),
    .front       (front),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .lb_we       (lb_we),
    .lb_waddr    (lb_waddr),
    .lb_wdata    (lb_wdata),
    .disp_bank   (disp_bank),
    .underrun    (underrun)
  );

  always #5 clk_25mhz = ~clk_25mhz;

  function automatic logic [15:0] pat(input logic [17:0] a);
    return a[15:0] ^ {a[17:16], 14'h0D5B};
  endfunction

  always @(posedge clk_25mhz) mem_rdata <= pat(mem_addr);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic chk_reset();
    chk("rst_front", front, 0);
    chk("rst_disp_bank", disp_bank, 1);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_lb_we", lb_we, 0);
    chk("rst_swap_done", swap_done, 0);
    chk("rst_underrun", underrun, 0);
  endtask

  // Caller raised the start pulse on the previous negedge.
  task automatic run_fetch(input int base, input logic bank,
                           input logic fr, input logic wrt,
                           input logic sd0);
    int nrd = 0;
    int nlb = 0;
    int nwr = 0;
    int ncyc = wrt ? 501 : 401;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk_25mhz);
      frame_start = 1'b0;
      line_start  = 1'b0;
      swap_req    = 1'b0;
      wr_valid    = wrt;
      wr_addr     = 17'(c * 7 + 3);
      wr_data     = 16'(c) ^ 16'h5A00;
      #1;
      if (c == 0) chk("swap_done_first", swap_done, sd0);
      if (c == 1) chk("swap_done_pulse", swap_done, 0);
      if (mem_we) begin
        nwr++;
        chk("wr_addr", mem_addr, {~fr, wr_addr});
        chk("wr_data", mem_wdata, wr_data);
      end else if (nrd < 400) begin
        chk("rd_addr", mem_addr, {fr, 17'(base + nrd)});
        nrd++;
      end
      if (lb_we) begin
        chk("lb_waddr", lb_waddr, {bank, 9'(nlb)});
        chk("lb_wdata", lb_wdata, pat({fr, 17'(base + nlb)}));
        nlb++;
      end
    end
    chk("read_count", nrd, 400);
    chk("lb_count", nlb, 400);
    chk("write_count", nwr, wrt ? 100 : 0);
    @(negedge clk_25mhz);
    wr_valid = 1'b1;
    wr_addr  = '0;
    #1;
    chk("idle_after_fetch", wr_ready, 1);
    wr_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nlbw;
    tv[0] = '{1'b1, 17'd5, 16'h1234, 1'b1, 1'b1, 18'h20005, 16'h1234};
    tv[1] = '{1'b0, 17'd7, 16'h4321, 1'b0, 1'b0, 18'h00000, 16'h0000};
    tv[2] = '{1'b1, 17'd95999, 16'hFFFF, 1'b1, 1'b1, 18'h376FF, 16'hFFFF};
    tv[3] = '{1'b1, 17'h1FFFF, 16'h0001, 1'b1, 1'b1, 18'h3FFFF, 16'h0001};

    wr_valid = 1'b1;
    repeat (2) @(negedge clk_25mhz);
    #1;
    chk_reset();
    @(negedge clk_25mhz);
    reset_n  = 1'b1;
    wr_valid = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk_25mhz);
      wr_valid = tv[i].wv;
      wr_addr  = tv[i].wa;
      wr_data  = tv[i].wd;
      #1;
      chk("tv_wr_ready", wr_ready, tv[i].ex_rdy);
      chk("tv_mem_we", mem_we, tv[i].ex_we);
      chk("tv_mem_addr", mem_addr, tv[i].ex_addr);
      chk("tv_mem_wdata", mem_wdata, tv[i].ex_wd);
    end
    wr_valid = 1'b0;

    @(negedge clk_25mhz);
    frame_start = 1'b1;
    run_fetch(0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("disp_bank_frame", disp_bank, 1);

    @(negedge clk_25mhz);
    frame_start = 1'b1;
    run_fetch(0, 1'b0, 1'b0, 1'b1, 1'b0);

    @(negedge clk_25mhz);
    line_start = 1'b1;
    next_y     = 11'd0;
    run_fetch(400, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("disp_bank_y0", disp_bank, 0);
    @(negedge clk_25mhz);
    line_start = 1'b1;
    next_y     = 11'd2;
    run_fetch(800, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("disp_bank_y2", disp_bank, 1);

    @(negedge clk_25mhz);
    line_start = 1'b1;
    next_y     = 11'd1;
    @(negedge clk_25mhz);
    line_start = 1'b0;
    wr_valid   = 1'b1;
    #1;
    chk("odd_line_idle", wr_ready, 1);
    chk("odd_line_bank", disp_bank, 1);
    wr_valid = 1'b0;

    @(negedge clk_25mhz);
    swap_req = 1'b1;
    @(negedge clk_25mhz);
    swap_req = 1'b0;
    #1;
    chk("swap_wait_front", front, 0);
    chk("swap_wait_done", swap_done, 0);
    repeat (5) @(negedge clk_25mhz);
    @(negedge clk_25mhz);
    frame_start = 1'b1;
    wr_valid    = 1'b1;
    wr_addr     = 17'd9;
    wr_data     = 16'hBEEF;
    #1;
    chk("swap_cycle_wr", mem_addr, 18'h20009);
    run_fetch(0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("swap_front", front, 1);
    @(negedge clk_25mhz);
    wr_valid = 1'b1;
    wr_addr  = 17'd5;
    #1;
    chk("post_swap_wr", mem_addr, 18'h00005);
    wr_valid = 1'b0;

    @(negedge clk_25mhz);
    frame_start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_25mhz);
      frame_start = 1'b0;
    end
    line_start = 1'b1;
    next_y     = 11'd0;
    #1;
    chk("abort_lb_drop", lb_we, 0);
    chk("underrun_before", underrun, 0);
    run_fetch(400, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("underrun_sticky", underrun, 1);

    @(negedge clk_25mhz);
    frame_start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_25mhz);
      frame_start = 1'b0;
    end
    #2;
    reset_n  = 1'b0;
    wr_valid = 1'b1;
    #1;
    chk_reset();
    @(negedge clk_25mhz);
    reset_n  = 1'b1;
    wr_valid = 1'b0;
    nlbw = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_25mhz);
      #1;
      if (lb_we) nlbw++;
    end
    chk("no_lb_after_reset", nlbw, 0);
    @(negedge clk_25mhz);
    frame_start = 1'b1;
    run_fetch(0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fb_scanout_arbiter.md
Name: fb_scanout_arbiter

Overview:
Owns the single-port 16-bit framebuffer RAM for the graphics system. It shares that RAM between two users:
- a line-prefetch engine that fills a two-bank line buffer feeding the HDMI scanout path (400x240 source, 2x upscaled to 800x480 display);
- a handshaked pixel writer from the graphics unit.
It also double-buffers frames: it holds a front/back frame select and swaps it at frame start on request.

Parameters:
SRC_W, 400, source pixels per line
SRC_H, 240, source lines per frame
ADDR_W, 17, writer address width (ceil(log2(SRC_W*SRC_H)))
WR_SHARE, 4, fetch reads issued between guaranteed writer slots while fetching

Ports:
clk_25mhz  in  1  system/pixel clock
reset_n  in  1  asynchronous active-low reset
frame_start  in  1  1-cycle pulse at start of vertical blank
line_start  in  1  1-cycle pulse at start of each active display line
next_y  in  11  display line that line_start refers to (0..479)
wr_valid  in  1  writer request
wr_ready  out  1  writer slot granted this cycle
wr_addr  in  ADDR_W  pixel index y*SRC_W+x in back frame
wr_data  in  16  RGB555+1 pixel
swap_req  in  1  request front/back swap at next frame_start
swap_done  out  1  1-cycle pulse when swap taken
front  out  1  frame currently scanned out
mem_addr  out  ADDR_W+1  {frame bit, pixel index}
mem_we  out  1  write strobe
mem_wdata  out  16  write data
mem_rdata  in  16  read data, valid 1 cycle after read address
lb_we  out  1  line-buffer write strobe
lb_waddr  out  10  {bank, 9-bit x}
lb_wdata  out  16  line-buffer data
disp_bank  out  1  line-buffer bank scanout must read
underrun  out  1  sticky: fetch not finished at its deadline

Behaviour:
- Reset values: front=0, disp_bank=1, swap pending=0, FSM=IDLE, wr_ready=0, mem_we=0, mem_addr=0, lb_we=0, swap_done=0, underrun=0.
- FSM states: IDLE, FETCH, DRAIN.
  - FETCH issues reads of source line s into bank fb (fill bank), x=0..SRC_W-1.
  - DRAIN waits one cycle for the final read's data, then returns to IDLE.
- frame_start:
  - If swap pending or swap_req is high this cycle: toggle front, pulse swap_done, clear pending.
  - Set disp_bank=1 and start fetch of line 0 into bank 0, using the new front.
- line_start with next_y even and next_y<2*SRC_H:
  - Toggle disp_bank.
  - If (next_y>>1)+1 < SRC_H, start fetch of line (next_y>>1)+1 into the bank not displayed.
- line_start with odd next_y: no action.
- Simultaneous frame_start and line_start: frame_start wins; line_start is ignored.
- Fetch start while FSM is not IDLE: set underrun, abort the old fetch (pending read data dropped), start the new one.
- Read pipeline: read at x issued in cycle t (mem_addr={front, s*SRC_W+x}, mem_we=0). In cycle t+1: lb_we=1, lb_waddr={fb, x}, lb_wdata=mem_rdata.
- Arbitration:
  - IDLE: wr_ready = wr_valid. A granted write drives mem_we=1, mem_addr={~front, wr_addr}, mem_wdata=wr_data in the same cycle.
  - FETCH: after every WR_SHARE consecutive reads, one slot goes to the writer if wr_valid, else the fetch continues.
  - Worst-case fetch = SRC_W + SRC_W/WR_SHARE + 1 = 501 cycles, well inside the 1600-cycle deadline.
  - wr_ready is combinational from state/counter and wr_valid. Transfer = wr_valid & wr_ready.
- Arithmetic: row base is an accumulated SRC_W step, not a multiply. Line and x counters wrap only via FSM exit. wr_addr >= SRC_W*SRC_H is written anyway (no check).
- swap_req is level-latched into pending. Writes granted in the same cycle as a swap target the pre-swap back frame.
- Reset mid-fetch returns everything to reset values immediately. No line-buffer write occurs after reset asserts.

Decomposition:
- Shared package gfx_pkg holds SRC_W, SRC_H, the display constants 800/480 and the pixel-format typedef (16-bit RGB555+1).
- One natural sub-module, fb_fetch_engine: FSM, x/row counters, read pipeline, WR_SHARE slot counter.
- Top level keeps swap logic, bank toggling and mux to the memory port.

Test Plan:
- Reset, then frame_start, wr_valid=0 -> reads at mem_addr 0..399 on consecutive cycles; lb_waddr {0,0..399} one cycle later; FSM IDLE after 401 cycles; disp_bank=1.
- wr_valid held high during a fetch, WR_SHARE=4 -> wr_ready pulses every 5th cycle; exactly 100 writes land at {~front, addr} in 501 cycles; no read lost or duplicated.
- line_start next_y=0 then 2 -> disp_bank toggles 1->0->1; fetches of lines 1 and 2 use base addresses 400 and 800 into banks 1 and 0.
- swap_req pulsed mid-frame -> no change until next frame_start; then front=1 and swap_done high for 1 cycle; following fetch reads start at mem_addr {1,0}; writer then targets {0,addr}.
- Second line_start forced 100 cycles after fetch start -> underrun=1 (sticky); new fetch starts cleanly at x=0.
- reset_n low in the middle of a fetch -> all outputs at reset values asynchronously; lb_we stays 0 after release until the next frame_start.
